y86_cc_unit: RTL and testbench

//   Condition-code register and condition evaluator at the consumer end of the 64-bit
//   add/sub datapath in the Y86-64 execute stage. Takes ALU operands and result, forms
//   ZF/SF/OF, holds them in the CC register, and resolves jXX/cmovXX conditions.

---
 rtl/y86_cc_if.sv | 34 +++
 rtl/y86_cc_unit.sv | 88 ++++++++
 tb/tb_y86_cc_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/y86_cc_if.sv
// Execute-stage condition-code channel: request side (operands, result, control)
// and registered response side (cnd/err/cc) with valid/ready on both.
interface y86_cc_if #(
  parameter int W = 64
);
  logic                in_valid;
  logic                in_ready;
  logic                set_cc;
  logic                eval_cnd;
  logic [3:0]          alu_fun;
  logic [3:0]          ifun;
  logic signed [W-1:0] op_a;
  logic signed [W-1:0] op_b;
  logic signed [W-1:0] alu_res;
  logic                cc_inhibit;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic                cnd;
  logic [2:0]          cc;
  logic                err;

  modport master (
    output in_valid, set_cc, eval_cnd, alu_fun, ifun, op_a, op_b, alu_res,
           cc_inhibit, flush, out_ready,
    input  in_ready, out_valid, cnd, cc, err
  );

  modport slave (
    input  in_valid, set_cc, eval_cnd, alu_fun, ifun, op_a, op_b, alu_res,
           cc_inhibit, flush, out_ready,
    output in_ready, out_valid, cnd, cc, err
  );
endinterface

// File: rtl/y86_cc_unit.sv
// Y86-64 condition-code register and jXX/cmovXX evaluator with a 1-deep
// registered output stage; conditions see the CC value from before the update.
module y86_cc_unit #(
  parameter int         W      = 64,
  parameter logic [2:0] CC_RST = 3'b100
) (
  input  logic       clk,
  input  logic       rst_n,
  y86_cc_if.slave    bus
);

  logic [2:0] cc_r;
  logic       vld_p1;
  logic       cnd_p1;
  logic       err_p1;

  logic accept, cc_we, fun_legal, ifun_legal;
  logic zf, sf, of;
  logic cnd_p0, err_p0;

  // Overflow from sign bits only; logic ops never overflow.
  function automatic logic calc_of(input logic [3:0] fun, input logic sa,
                                   input logic sb, input logic sr);
    case (fun)
      4'd0:    calc_of = (sa == sb) && (sr != sa);
      4'd1:    calc_of = (sa != sb) && (sr != sb);
      default: calc_of = 1'b0;
    endcase
  endfunction

  // flags = {ZF,SF,OF}
  function automatic logic cond_met(input logic [3:0] fn, input logic [2:0] flags);
    logic lt;
    lt = flags[1] ^ flags[0];
    case (fn)
      4'd0:    cond_met = 1'b1;
      4'd1:    cond_met = lt | flags[2];
      4'd2:    cond_met = lt;
      4'd3:    cond_met = flags[2];
      4'd4:    cond_met = !flags[2];
      4'd5:    cond_met = !lt;
      4'd6:    cond_met = !lt && !flags[2];
      default: cond_met = 1'b0;
    endcase
  endfunction

  assign bus.in_ready  = !vld_p1 || bus.out_ready;
  assign bus.out_valid = vld_p1;
  assign bus.cnd       = cnd_p1;
  assign bus.err       = err_p1;
  assign bus.cc        = cc_r;

  // p0: flag formation and condition evaluation on the incoming transaction
  always_comb begin
    accept     = bus.in_valid && bus.in_ready;
    fun_legal  = bus.alu_fun <= 4'd3;
    ifun_legal = bus.ifun <= 4'd6;
    zf         = (bus.alu_res == '0);
    sf         = bus.alu_res[W-1];
    of         = calc_of(bus.alu_fun, bus.op_a[W-1], bus.op_b[W-1], bus.alu_res[W-1]);
    cc_we      = accept && bus.set_cc && !bus.cc_inhibit && !bus.flush && fun_legal;
    cnd_p0     = bus.eval_cnd && ifun_legal && cond_met(bus.ifun, cc_r);
    err_p0     = (bus.set_cc && !fun_legal) || (bus.eval_cnd && !ifun_legal);
  end

  // p1: CC register and registered output stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc_r   <= CC_RST;
      vld_p1 <= 1'b0;
      cnd_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      if (cc_we)
        cc_r <= {zf, sf, of};
      if (bus.flush) begin
        vld_p1 <= 1'b0;
      end else if (accept) begin
        vld_p1 <= 1'b1;
        cnd_p1 <= cnd_p0;
        err_p1 <= err_p0;
      end else if (bus.out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_y86_cc_unit.sv
// Bench for y86_cc_unit: directed scenarios plus random traffic, checked by a
// scoreboard fed from an arithmetic reference model of the flags and conditions.
module tb_y86_cc_unit;
  localparam int W = 64;
  localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] MINN = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  y86_cc_if #(.W(W)) bus ();
  y86_cc_unit #(.W(W), .CC_RST(3'b100)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic cnd;
    logic err;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] m_cc;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] alu(input logic [3:0] fun, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    case (fun)
      4'd0:    alu = b + a;
      4'd1:    alu = b - a;
      4'd2:    alu = a & b;
      4'd3:    alu = a ^ b;
      default: alu = {$urandom, $urandom};
    endcase
  endfunction

  // {ZF,SF,OF}: OF set when the exact signed result does not fit in W bits
  function automatic logic [2:0] flags(input logic [3:0] fun, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic [W-1:0] res);
    logic signed [W:0] exact;
    logic of;
    of = 1'b0;
    if (fun == 4'd0) begin
      exact = $signed({b[W-1], b}) + $signed({a[W-1], a});
      of = (exact != $signed({res[W-1], res}));
    end else if (fun == 4'd1) begin
      exact = $signed({b[W-1], b}) - $signed({a[W-1], a});
      of = (exact != $signed({res[W-1], res}));
    end
    flags = {res == '0, res[W-1], of};
  endfunction

  function automatic logic holds(input logic [3:0] fn, input logic [2:0] f);
    logic less, zero;
    zero = f[2];
    less = (f[1] != f[0]);
    case (fn)
      4'd0: holds = 1'b1;
      4'd1: holds = less || zero;
      4'd2: holds = less;
      4'd3: holds = zero;
      4'd4: holds = !zero;
      4'd5: holds = !less;
      4'd6: holds = !less && !zero;
      default: holds = 1'b0;
    endcase
  endfunction

  // Monitor: runs on the falling edge, before the driver commits its model update.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", bus.out_valid, sb.size() != 0);
      check("in_ready", bus.in_ready, (sb.size() == 0) || bus.out_ready);
      check("cc", bus.cc, m_cc);
      if (bus.out_valid && sb.size() != 0) begin
        check("cnd", bus.cnd, sb[0].cnd);
        check("err", bus.err, sb[0].err);
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic cyc(input logic v, input logic sc, input logic ev, input logic [3:0] fun,
                     input logic [3:0] ifn, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] res, input logic inh, input logic fl,
                     input logic ordy);
    exp_t e;
    @(posedge clk); #1;
    bus.in_valid   = v;
    bus.set_cc     = sc;
    bus.eval_cnd   = ev;
    bus.alu_fun    = fun;
    bus.ifun       = ifn;
    bus.op_a       = a;
    bus.op_b       = b;
    bus.alu_res    = res;
    bus.cc_inhibit = inh;
    bus.flush      = fl;
    bus.out_ready  = ordy;
    @(negedge clk); #1;
    if (fl) begin
      sb.delete();
    end else if (v && sb.size() == 0) begin
      e.cnd = ev && holds(ifn, m_cc);
      e.err = (sc && fun > 4'd3) || (ev && ifn > 4'd6);
      sb.push_back(e);
      if (sc && !inh && fun <= 4'd3) m_cc = flags(fun, a, b, res);
    end
  endtask

  task automatic op(input logic sc, input logic ev, input logic [3:0] fun, input logic [3:0] ifn,
                    input logic [W-1:0] a, input logic [W-1:0] b, input logic inh,
                    input logic fl, input logic ordy);
    cyc(1'b1, sc, ev, fun, ifn, a, b, alu(fun, a, b), inh, fl, ordy);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0:       pick = MAXP;
      1:       pick = MINN;
      2:       pick = '0;
      3:       pick = 64'($urandom_range(0, 3)) - 64'd2;
      default: pick = {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    bus.in_valid = 1'b0; bus.set_cc = 1'b0; bus.eval_cnd = 1'b0;
    bus.alu_fun = '0; bus.ifun = '0; bus.op_a = '0; bus.op_b = '0; bus.alu_res = '0;
    bus.cc_inhibit = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    m_cc = 3'b100;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cc", bus.cc, 3'b100);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_cnd", bus.cnd, 1'b0);
    check("rst_err", bus.err, 1'b0);
    rst_n = 1'b1;

    // sub 20-50 = -30, then "l"
    op(1, 0, 4'd1, 4'd0, 64'd50, 64'd20, 0, 0, 1);
    op(0, 1, 4'd0, 4'd2, '0, '0, 0, 0, 1);
    check("cc_after_sub", bus.cc, 3'b010);

    // positive overflow on add, then ge and g
    op(1, 0, 4'd0, 4'd0, MAXP, MAXP, 0, 0, 1);
    op(0, 1, 4'd0, 4'd5, '0, '0, 0, 0, 1);
    check("cc_after_add_ovf", bus.cc, 3'b011);
    op(0, 1, 4'd0, 4'd6, '0, '0, 0, 0, 1);

    // backpressure: three stalled cycles, then release
    for (int i = 0; i < 3; i++) op(0, 1, 4'd0, 4'd3, '0, '0, 0, 0, 0);
    check("stall_in_ready", bus.in_ready, 1'b0);
    op(0, 1, 4'd0, 4'd4, '0, '0, 0, 0, 1);
    op(0, 1, 4'd0, 4'd1, '0, '0, 0, 0, 1);

    // cc_inhibit keeps CC but still produces output; flush drops everything
    op(1, 0, 4'd1, 4'd0, 64'd50, 64'd20, 0, 0, 1);
    op(1, 1, 4'd1, 4'd3, 64'd5, 64'd5, 1, 0, 1);
    op(1, 0, 4'd1, 4'd0, 64'd7, 64'd7, 0, 1, 1);
    idle();
    check("cc_after_inhibit_flush", bus.cc, 3'b010);

    // illegal ifun and alu_fun
    op(0, 1, 4'd0, 4'd9, '0, '0, 0, 0, 1);
    op(1, 0, 4'd5, 4'd0, 64'd1, 64'd1, 0, 0, 1);
    idle();
    check("cc_after_illegal", bus.cc, 3'b010);

    for (int i = 0; i < 600; i++) begin
      logic [3:0] fun, ifn;
      fun = ($urandom % 8 != 0) ? 4'($urandom % 4) : 4'($urandom_range(4, 15));
      ifn = ($urandom % 8 != 0) ? 4'($urandom % 7) : 4'($urandom_range(7, 15));
      cyc(($urandom % 4) != 0, 1'($urandom), 1'($urandom), fun, ifn, '0, '0, '0,
          1'b0, 1'b0, 1'b1);
      if ($urandom % 2 != 0) begin
        logic [W-1:0] a, b;
        a = pick();
        b = pick();
        op(1'($urandom), 1'($urandom), fun, ifn, a, b, ($urandom % 10) == 0,
           ($urandom % 16) == 0, ($urandom % 4) != 0);
      end
    end

    repeat (3) idle();
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
